i_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage for the MIPS pipeline: holds the instruction memory, owns the PC and feeds decode through a QUEUE_DEPTH-entry prefetch queue with a valid/ready handshake. It adds back-pressure, queue flush on branch/jump redirect, halt draining and single-step debug fetch. It sits between the debug/loader unit (program load, start, step) and the IF/ID boundary. Redirects come from the branch/jump resolution logic.

---
 rtl/i_fetch_queue.sv | 166 ++++++++++++++++
 tb/tb_i_fetch_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i_fetch_queue.sv
// Instruction-fetch stage: instruction memory, PC and prefetch queue with valid/ready handshake.
// Step-mode debug fetch is built only when FETCH_STEP_EN is defined; otherwise fetch is always continuous.
module i_fetch_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = 'hFC000000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic                  i_step,
  input  logic                  i_loading,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  input  logic                  i_redirect,
  input  logic [DATA_WIDTH-1:0] i_redirect_pc,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_pc_incr,
  output logic [DATA_WIDTH-1:0] o_pc_debug,
  output logic                  o_halted
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned MEM_DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t state, state_d;

  logic [DATA_WIDTH-1:0] pc, pc_d, pc_plus4;
  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];
  logic [DATA_WIDTH-1:0] fetch_word;

  logic [DATA_WIDTH-1:0] q_instr [0:QUEUE_DEPTH-1];
  logic [DATA_WIDTH-1:0] q_pc    [0:QUEUE_DEPTH-1];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  logic full, pop, push, fetch, flush, start_ok, redirect_act, head_halt, step_ok;

  assign pc_plus4     = pc + DATA_WIDTH'(4);
  assign fetch_word   = mem[pc[ADDR_WIDTH+1:2]];
  assign full         = (count == CNT_W'(QUEUE_DEPTH));
  assign o_valid      = (count != '0);
  assign pop          = o_valid & i_ready;
  assign head_halt    = (q_instr[rd_ptr] == HALT_WORD);
  assign redirect_act = i_redirect && ((state == S_RUN) || (state == S_DRAIN));
  assign fetch        = (state == S_RUN) && (!full || pop) && !redirect_act && step_ok;
  assign push         = fetch;

  assign o_instruccion = o_valid ? q_instr[rd_ptr] : '0;
  assign o_pc_incr     = o_valid ? q_pc[rd_ptr] : '0;
  assign o_pc_debug    = pc;
  assign o_halted      = (state == S_HALTED);

`ifdef FETCH_STEP_EN
  logic mode_q, armed, step_prev, step_rise;

  assign step_rise = i_step & ~step_prev;
  assign step_ok   = ~mode_q | armed;

  // Edges arriving while already armed are absorbed; consuming fetch or redirect disarms.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      mode_q    <= 1'b0;
      armed     <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      step_prev <= i_step;
      if (start_ok) mode_q <= i_mode;
      if (redirect_act || fetch) armed <= 1'b0;
      else if (step_rise)        armed <= 1'b1;
    end
  end
`else
  logic unused_step;

  assign step_ok     = 1'b1;
  assign unused_step = i_mode ^ i_step;
`endif

  always_comb begin
    state_d  = state;
    pc_d     = pc;
    flush    = 1'b0;
    start_ok = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start && !i_loading) begin
          state_d  = S_RUN;
          start_ok = 1'b1;
        end
      end
      S_RUN: begin
        if (redirect_act) begin
          pc_d  = i_redirect_pc;
          flush = 1'b1;
        end else if (fetch) begin
          // HALT_WORD is queued but the PC stays on it.
          if (fetch_word == HALT_WORD) state_d = S_DRAIN;
          else                         pc_d    = pc_plus4;
        end
      end
      S_DRAIN: begin
        if (redirect_act) begin
          state_d = S_RUN;
          pc_d    = i_redirect_pc;
          flush   = 1'b1;
        end else if (pop && head_halt) begin
          state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        if (i_start) begin
          state_d  = S_RUN;
          pc_d     = '0;
          flush    = 1'b1;
          start_ok = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state  <= S_IDLE;
      pc     <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage has no reset: memory must survive reset, and queue slots are masked by count.
  always_ff @(posedge i_clock) begin
    if (state == S_IDLE && i_loading) mem[i_load_addr] <= i_load_data;
    if (push) begin
      q_instr[wr_ptr] <= fetch_word;
      q_pc[wr_ptr]    <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_i_fetch_queue.sv
// Directed self-checking bench for i_fetch_queue: load, continuous fetch, back-pressure,
// redirect flush, drain/redirect, asynchronous reset and (with FETCH_STEP_EN) step mode.
module tb_i_fetch_queue;

  localparam logic [31:0] HALT = 32'hFC000000;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_mode = 1'b0;
  logic        i_step = 1'b0;
  logic        i_loading = 1'b0;
  logic [9:0]  i_load_addr = '0;
  logic [31:0] i_load_data = '0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_ready = 1'b0;
  logic        o_valid;
  logic [31:0] o_instruccion;
  logic [31:0] o_pc_incr;
  logic [31:0] o_pc_debug;
  logic        o_halted;

  int n_checks = 0;
  int n_errors = 0;
  int delivered = 0;

  i_fetch_queue #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .QUEUE_DEPTH(4),
    .HALT_WORD(32'hFC000000)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_start(i_start),
    .i_mode(i_mode),
    .i_step(i_step),
    .i_loading(i_loading),
    .i_load_addr(i_load_addr),
    .i_load_data(i_load_data),
    .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .i_ready(i_ready),
    .o_valid(o_valid),
    .o_instruccion(o_instruccion),
    .o_pc_incr(o_pc_incr),
    .o_pc_debug(o_pc_debug),
    .o_halted(o_halted)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [9:0] addr, input logic [31:0] data);
    i_loading   = 1'b1;
    i_load_addr = addr;
    i_load_data = data;
    tick();
    i_loading   = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] instr, input logic [31:0] pci);
    check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    check({tag, "_instr"}, o_instruccion, instr);
    check({tag, "_pcincr"}, o_pc_incr, pci);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    check({tag, "_instr"}, o_instruccion, 32'd0);
    check({tag, "_pcincr"}, o_pc_incr, 32'd0);
  endtask

  task automatic run_steps(input int unsigned n, input logic step_level);
    i_step = step_level;
    for (int unsigned k = 0; k < n; k++) begin
      tick();
      if (o_valid) delivered++;
    end
  endtask

  initial begin
    // Reset state
    #1 i_reset = 1'b0;
    #2;
    check_empty("rst");
    check("rst_pc", o_pc_debug, 32'd0);
    check("rst_halted", {31'd0, o_halted}, 32'd0);
    #4 i_reset = 1'b1;
    tick();

    // Program: 1,2,3,HALT then 0x100+i
    load(10'd0, 32'd1);
    load(10'd1, 32'd2);
    load(10'd2, 32'd3);
    load(10'd3, HALT);
    for (int i = 4; i < 16; i++) load(10'(i), 32'h100 + 32'(i));

    // Continuous run to halt
    i_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_empty("run_n1");
    tick(); check_head("run_w0", 32'd1, 32'd4);
    tick(); check_head("run_w1", 32'd2, 32'd8);
    tick(); check_head("run_w2", 32'd3, 32'd12);
    tick(); check_head("run_w3", HALT, 32'd16);
    check("drain_halted", {31'd0, o_halted}, 32'd0);
    check("drain_pc", o_pc_debug, 32'd12);
    tick();
    check("halted", {31'd0, o_halted}, 32'd1);
    check("halted_valid", {31'd0, o_valid}, 32'd0);
    check("halted_pc", o_pc_debug, 32'd12);

    // Back-pressure: reset to reload mem[3], then stall decode
    i_reset = 1'b0;
    #2;
    check("rst2_halted", {31'd0, o_halted}, 32'd0);
    check("rst2_pc", o_pc_debug, 32'd0);
    i_reset = 1'b1;
    tick();
    load(10'd3, 32'h103);
    i_ready = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("bp_pc", o_pc_debug, 32'd16);
    check_head("bp_head", 32'd1, 32'd4);
    i_ready = 1'b1;
    tick(); check_head("bp_r1", 32'd2, 32'd8);
    tick(); check_head("bp_r2", 32'd3, 32'd12);
    tick(); check_head("bp_r3", 32'h103, 32'd16);
    tick(); check_head("bp_r4", 32'h104, 32'd20);
    tick(); check_head("bp_r5", 32'h105, 32'd24);

    // Redirect flush
    i_ready       = 1'b0;
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h10;
    tick();
    i_redirect = 1'b0;
    check_empty("rd1_flush");
    check("rd1_pc", o_pc_debug, 32'h10);
    tick(); check_head("rd1_head", 32'h104, 32'h14);
    tick();
    tick();
    check("rd1_pc3", o_pc_debug, 32'h1C);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h20;
    i_ready       = 1'b1;
    tick();
    i_redirect = 1'b0;
    check_empty("rd2_flush");
    check("rd2_pc", o_pc_debug, 32'h20);
    tick(); check_head("rd2_w8", 32'h108, 32'h24);
    tick(); check_head("rd2_w9", 32'h109, 32'h28);

    // Asynchronous reset mid-run
    i_reset = 1'b0;
    #2;
    check_empty("arst");
    check("arst_pc", o_pc_debug, 32'd0);
    i_reset = 1'b1;
    tick();

    // Redirect during drain
    load(10'd2, HALT);
    i_ready = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); check_head("rex_w0", 32'd1, 32'd4);
    tick();
    tick();
    check("dr_pc", o_pc_debug, 32'd8);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h10;
    tick();
    i_redirect = 1'b0;
    check_empty("dr_flush");
    check("dr_halted", {31'd0, o_halted}, 32'd0);
    check("dr_pc2", o_pc_debug, 32'h10);
    i_ready = 1'b1;
    tick(); check_head("dr_w4", 32'h104, 32'h14);
    check("dr_halted2", {31'd0, o_halted}, 32'd0);

`ifdef FETCH_STEP_EN
    // Step mode: three edges, one held for five cycles
    i_reset = 1'b0;
    #2 i_reset = 1'b1;
    tick();
    load(10'd2, 32'h102);
    i_ready = 1'b1;
    i_mode  = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_mode  = 1'b0;
    delivered = 0;
    run_steps(3, 1'b0);
    check("st_none", 32'(delivered), 32'd0);
    run_steps(1, 1'b1);
    run_steps(3, 1'b0);
    run_steps(5, 1'b1);
    run_steps(3, 1'b0);
    run_steps(1, 1'b1);
    run_steps(4, 1'b0);
    check("st_count", 32'(delivered), 32'd3);
    check("st_pc", o_pc_debug, 32'd12);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
